mac_dot_seq: RTL and testbench

Sequencer that drives the floating-point MAC pipeline through an N-term dot product: acc = init_c + Σ a[i]·b[i]. It pulls operand pairs over a valid/ready stream and issues one MAC operation at a time. Each result is fed back as the C operand of the next issue. The block sits between the operand source and the MAC pipeline, and reports the final accumulator with a one-cycle done pulse.

---
 rtl/mac_dot_seq_if.sv | 43 ++++
 rtl/mac_dot_seq.sv | 129 ++++++++++++
 tb/tb_mac_dot_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_seq_if.sv
// Sequencer-facing bundle: job control, operand stream, MAC issue/result and status.
// master = the sequencer, slave = the environment (operand source, MAC pipeline, host).
interface mac_dot_seq_if;
  logic        start;
  logic [7:0]  len;
  logic [31:0] init_c;
  logic        abort;

  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic        mac_in_valid;
  logic [31:0] mac_a;
  logic [31:0] mac_b;
  logic [31:0] mac_c;
  logic        mac_out_valid;
  logic [31:0] mac_out;

  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;

  modport master (
    input  start, len, init_c, abort,
    input  op_valid, op_a, op_b,
    output op_ready,
    output mac_in_valid, mac_a, mac_b, mac_c,
    input  mac_out_valid, mac_out,
    output busy, done, result, err
  );

  modport slave (
    output start, len, init_c, abort,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  mac_in_valid, mac_a, mac_b, mac_c,
    output mac_out_valid, mac_out,
    input  busy, done, result, err
  );
endinterface

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: one MAC in flight, result fed back as C; done is registered out of FIN.
// Operands are accepted only in FETCH; a missing MAC response ends the job with a sticky err.
module mac_dot_seq #(
  parameter int LAT = 5,
  parameter int TMO = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mac_dot_seq_if.master io
);
  // The timeout window must outlast the pipeline, so it is never shorter than LAT+1.
  localparam int TMO_EFF = (TMO > LAT) ? TMO : LAT + 1;
  localparam int TW      = $clog2(TMO_EFF + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   acc_q, acc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   mac_a_q, mac_a_d;
  logic [31:0]   mac_b_q, mac_b_d;
  logic [31:0]   mac_c_q, mac_c_d;
  logic          mac_vld_q, mac_vld_d;
  logic [31:0]   result_q, result_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    mac_a_d   = mac_a_q;
    mac_b_d   = mac_b_q;
    mac_c_d   = mac_c_q;
    mac_vld_d = 1'b0;
    result_d  = result_q;
    done_d    = 1'b0;
    err_d     = err_q;

    // Abort outranks every other transition and suppresses issue and done.
    if (io.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.start) begin
            acc_d   = io.init_c;
            cnt_d   = io.len;
            err_d   = 1'b0;
            state_d = (io.len != 8'd0) ? S_FETCH : S_FIN;
          end
        end
        S_FETCH: begin
          if (io.op_valid) begin
            mac_a_d   = io.op_a;
            mac_b_d   = io.op_b;
            mac_c_d   = acc_q;
            mac_vld_d = 1'b1;
            timer_d   = TW'(TMO_EFF);
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          // A response landing on the expiry cycle still wins over the timeout.
          if (io.mac_out_valid) begin
            acc_d   = io.mac_out;
            cnt_d   = cnt_q - 8'd1;
            state_d = (cnt_q == 8'd1) ? S_FIN : S_FETCH;
          end else if (timer_q == '0) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_FIN: begin
          result_d = acc_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_c_q   <= '0;
      mac_vld_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
      mac_c_q   <= mac_c_d;
      mac_vld_q <= mac_vld_d;
      result_q  <= result_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign io.op_ready     = (state_q == S_FETCH);
  assign io.mac_in_valid = mac_vld_q;
  assign io.mac_a        = mac_a_q;
  assign io.mac_b        = mac_b_q;
  assign io.mac_c        = mac_c_q;
  assign io.busy         = (state_q != S_IDLE);
  assign io.done         = done_q;
  assign io.result       = result_q;
  assign io.err          = err_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a fixed-latency MAC responder fed from a response table.
module tb_mac_dot_seq;
  localparam int LAT = 5;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_dot_seq_if io_if ();

  mac_dot_seq #(.LAT(LAT), .TMO(TMO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (io_if)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed MAC responses, consumed one per issue; drop_q marks a lost response.
  logic [31:0] resp_q[$];
  bit          drop_q[$];
  logic [31:0] iss_a[$];
  logic [31:0] iss_b[$];
  logic [31:0] iss_c[$];
  int          n_issue  = 0;
  int          spur_cnt = 0;

  initial begin : mac_model
    int          delay;
    int          spur_seen;
    logic [31:0] r;
    bit          d;
    delay = 0;
    spur_seen = 0;
    r = '0;
    d = 1'b0;
    io_if.mac_out_valid = 1'b0;
    io_if.mac_out = '0;
    forever begin
      @(posedge clk);
      #1;
      io_if.mac_out_valid = 1'b0;
      if (delay > 0) begin
        delay--;
        if (delay == 0 && !d) begin
          io_if.mac_out_valid = 1'b1;
          io_if.mac_out = r;
        end
      end else if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        io_if.mac_out_valid = 1'b1;
        io_if.mac_out = 32'hDEADBEEF;
      end
      if (io_if.mac_in_valid) begin
        n_issue++;
        iss_a.push_back(io_if.mac_a);
        iss_b.push_back(io_if.mac_b);
        iss_c.push_back(io_if.mac_c);
        r = (resp_q.size() > 0) ? resp_q.pop_front() : 32'h0;
        d = (drop_q.size() > 0) ? drop_q.pop_front() : 1'b0;
        delay = LAT;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns the cycle index in which start is high; latencies are measured from it.
  task automatic do_start(input logic [7:0] l, input logic [31:0] c, output int s);
    io_if.start = 1'b1;
    io_if.len = l;
    io_if.init_c = c;
    s = cyc;
    tick();
    io_if.start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int d, output int rdy_seen);
    d = -1;
    rdy_seen = 0;
    for (int i = 0; i < bound; i++) begin
      if (io_if.done) begin
        d = cyc;
        break;
      end
      if (io_if.op_ready) rdy_seen++;
      tick();
    end
  endtask

  task automatic wait_issue(input int n, input int base);
    for (int i = 0; i < 60; i++) begin
      if (n_issue - base >= n) break;
      tick();
    end
    chk("issue_reached", 32'(n_issue - base), 32'(n));
  endtask

  task automatic clear_log();
    iss_a.delete();
    iss_b.delete();
    iss_c.delete();
  endtask

  initial begin : stim
    int s;
    int d;
    int rdy;
    int base;
    int cnt;
    io_if.start = 1'b0;
    io_if.len = '0;
    io_if.init_c = '0;
    io_if.abort = 1'b0;
    io_if.op_valid = 1'b0;
    io_if.op_a = '0;
    io_if.op_b = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_op_ready", 32'(io_if.op_ready), 32'd0);
    chk("rst_mac_in_valid", 32'(io_if.mac_in_valid), 32'd0);
    chk("rst_busy", 32'(io_if.busy), 32'd0);
    chk("rst_done", 32'(io_if.done), 32'd0);
    chk("rst_err", 32'(io_if.err), 32'd0);
    chk("rst_mac_c", io_if.mac_c, 32'h0);
    chk("rst_result", io_if.result, 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic job: 0 + 3 x (1.0 * 2.0) = 6.0
    resp_q = '{32'h40000000, 32'h40800000, 32'h40C00000};
    clear_log();
    base = n_issue;
    io_if.op_valid = 1'b1;
    io_if.op_a = 32'h3F800000;
    io_if.op_b = 32'h40000000;
    do_start(8'd3, 32'h0, s);
    chk("basic_busy_rise", 32'(io_if.busy), 32'd1);
    wait_done(200, d, rdy);
    chk("basic_latency", 32'(d - s), 32'd23);
    chk("basic_result", io_if.result, 32'h40C00000);
    chk("basic_err", 32'(io_if.err), 32'd0);
    chk("basic_issues", 32'(n_issue - base), 32'd3);
    chk("basic_c0", iss_c[0], 32'h00000000);
    chk("basic_c1", iss_c[1], 32'h40000000);
    chk("basic_c2", iss_c[2], 32'h40800000);
    chk("basic_a0", iss_a[0], 32'h3F800000);
    chk("basic_b0", iss_b[0], 32'h40000000);
    tick();
    chk("basic_done_pulse", 32'(io_if.done), 32'd0);
    chk("basic_busy_fall", 32'(io_if.busy), 32'd0);

    // Zero length: done two cycles after start, result = init_c
    io_if.op_valid = 1'b0;
    clear_log();
    base = n_issue;
    do_start(8'd0, 32'h41200000, s);
    wait_done(20, d, rdy);
    chk("zero_latency", 32'(d - s), 32'd2);
    chk("zero_result", io_if.result, 32'h41200000);
    chk("zero_no_ready", 32'(rdy), 32'd0);
    chk("zero_no_issue", 32'(n_issue - base), 32'd0);

    // Timeout: second response lost
    resp_q = '{32'h40000000, 32'h0};
    drop_q = '{1'b0, 1'b1};
    clear_log();
    base = n_issue;
    io_if.op_valid = 1'b1;
    io_if.op_a = 32'h3F800000;
    io_if.op_b = 32'h40000000;
    do_start(8'd2, 32'h0, s);
    wait_done(200, d, rdy);
    chk("tmo_done_seen", 32'(d >= 0), 32'd1);
    chk("tmo_err", 32'(io_if.err), 32'd1);
    chk("tmo_result", io_if.result, 32'h40000000);
    chk("tmo_issues", 32'(n_issue - base), 32'd2);
    drop_q.delete();

    // Backpressure and a spurious MAC response in FETCH: 1.0 + 1.0*2.0 + 2.0*2.0 = 7.0
    io_if.op_valid = 1'b0;
    resp_q = '{32'h40400000, 32'h40E00000};
    clear_log();
    base = n_issue;
    do_start(8'd2, 32'h3F800000, s);
    chk("bp_err_cleared", 32'(io_if.err), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (io_if.op_ready) cnt++;
      if (i == 3) spur_cnt++;
      tick();
    end
    chk("bp_ready_held", 32'(cnt), 32'd10);
    chk("bp_no_issue", 32'(n_issue - base), 32'd0);
    io_if.op_valid = 1'b1;
    io_if.op_a = 32'h3F800000;
    io_if.op_b = 32'h40000000;
    wait_issue(1, base);
    io_if.op_a = 32'h40000000;
    io_if.op_b = 32'h40000000;
    wait_done(200, d, rdy);
    chk("bp_c0", iss_c[0], 32'h3F800000);
    chk("bp_c1", iss_c[1], 32'h40400000);
    chk("bp_a1", iss_a[1], 32'h40000000);
    chk("bp_result", io_if.result, 32'h40E00000);

    // start pulsed mid-job is ignored
    io_if.op_a = 32'h3F800000;
    io_if.op_b = 32'h40000000;
    resp_q = '{32'h40000000, 32'h40800000, 32'h40C00000};
    clear_log();
    base = n_issue;
    do_start(8'd3, 32'h0, s);
    repeat (4) tick();
    io_if.start = 1'b1;
    io_if.len = 8'd1;
    io_if.init_c = 32'h12345678;
    tick();
    io_if.start = 1'b0;
    wait_done(200, d, rdy);
    chk("swb_latency", 32'(d - s), 32'd23);
    chk("swb_result", io_if.result, 32'h40C00000);
    chk("swb_issues", 32'(n_issue - base), 32'd3);

    // Abort in WAIT of term 2: no done, result kept
    resp_q = '{32'h40000000, 32'h40800000, 32'h40C00000};
    clear_log();
    base = n_issue;
    do_start(8'd3, 32'h0, s);
    wait_issue(2, base);
    io_if.abort = 1'b1;
    tick();
    io_if.abort = 1'b0;
    chk("abort_busy", 32'(io_if.busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (io_if.done) cnt++;
      tick();
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    chk("abort_result_kept", io_if.result, 32'h40C00000);
    chk("abort_issues", 32'(n_issue - base), 32'd2);
    resp_q.delete();

    // Reset during WAIT
    resp_q = '{32'h40000000, 32'h40800000};
    clear_log();
    base = n_issue;
    do_start(8'd2, 32'h0, s);
    wait_issue(1, base);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_busy", 32'(io_if.busy), 32'd0);
    chk("mrst_op_ready", 32'(io_if.op_ready), 32'd0);
    chk("mrst_mac_in_valid", 32'(io_if.mac_in_valid), 32'd0);
    chk("mrst_result", io_if.result, 32'h0);
    chk("mrst_mac_a", io_if.mac_a, 32'h0);
    rst_n = 1'b1;
    repeat (8) tick();
    resp_q.delete();

    // Follow-up job after reset: 2.0 + 1.0*2.0 = 4.0
    resp_q = '{32'h40800000};
    clear_log();
    base = n_issue;
    do_start(8'd1, 32'h40000000, s);
    wait_done(100, d, rdy);
    chk("post_latency", 32'(d - s), 32'd9);
    chk("post_result", io_if.result, 32'h40800000);
    chk("post_c0", iss_c[0], 32'h40000000);
    chk("post_err", 32'(io_if.err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
